// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MemtoReg result-select encodings and the
// data-memory access FSM state type.
`timescale 1ns/1ps
package mips_pkg;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_LO  = 2'b10;
    localparam logic [1:0] MTR_HI  = 2'b11;

    typedef enum logic {
        StIdle,
        StWait
    } memState_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: request/stall generation, wait counter with
// timeout abort, and the sticky misalign/timeout error flag.
`timescale 1ns/1ps
module mem_access_fsm
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       MemWriteM,
    input  logic [1:0] MemtoRegM,
    input  logic [1:0] addrLowM,
    input  logic       dmem_ready,
    output logic       dmem_req,
    output logic       StallM,
    output logic       dropM,
    output logic       ErrM
);

    memState_t        state;
    logic [CNT_W-1:0] cnt;
    logic             memOpM;
    logic             misalignedM;
    logic             timeoutHit;

    assign memOpM      = MemWriteM | (MemtoRegM == MTR_MEM);
    assign misalignedM = memOpM & (addrLowM != 2'b00);

    always_comb begin
        dmem_req   = 1'b0;
        StallM     = 1'b0;
        dropM      = 1'b0;
        timeoutHit = 1'b0;
        unique case (state)
            StIdle: begin
                dmem_req = memOpM & ~misalignedM;
                StallM   = memOpM & ~misalignedM & ~dmem_ready;
                dropM    = misalignedM;
            end
            StWait: begin
                dmem_req   = 1'b1;
                timeoutHit = ~dmem_ready & (cnt == CNT_W'(TIMEOUT));
                // Abort cycle releases the stall so the op retires as a bubble
                StallM     = ~dmem_ready & ~timeoutHit;
                dropM      = timeoutHit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            cnt   <= '0;
            ErrM  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (misalignedM) begin
                        ErrM <= 1'b1;
                    end else if (memOpM && !dmem_ready) begin
                        state <= StWait;
                        cnt   <= CNT_W'(1);
                    end
                end
                StWait: begin
                    if (dmem_ready || timeoutHit) begin
                        state <= StIdle;
                        cnt   <= '0;
                        if (timeoutHit) ErrM <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: E/M and M/W pipeline registers, data-memory handshake via
// mem_access_fsm, and the writeback result mux.
`timescale 1ns/1ps
module memory_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        jumpE,
    input  logic [1:0]  MemtoRegE,
    input  logic [4:0]  WriteRegE,
    input  logic [31:0] ALUMultOutE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCPlus4E,
    input  logic        FlushM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic        RegWriteM,
    output logic [1:0]  MemtoRegM,
    output logic        StallM,
    output logic        ErrM,
    output logic        RegWriteW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ResultW
);

    logic        MemWriteM;
    logic        jumpM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        dropM;

    logic        jumpW;
    logic [1:0]  MemtoRegW;
    logic [31:0] ALUOutW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;

    // E/M register: stall holds (and overrides flush), flush loads a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            jumpM      <= 1'b0;
            MemtoRegM  <= MTR_ALU;
            WriteRegM  <= '0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (!StallM) begin
            if (FlushM) begin
                RegWriteM  <= 1'b0;
                MemWriteM  <= 1'b0;
                jumpM      <= 1'b0;
                MemtoRegM  <= MTR_ALU;
                WriteRegM  <= '0;
                ALUOutM    <= '0;
                WriteDataM <= '0;
                PCPlus4M   <= '0;
            end else begin
                RegWriteM  <= RegWriteE;
                MemWriteM  <= MemWriteE;
                jumpM      <= jumpE;
                MemtoRegM  <= MemtoRegE;
                WriteRegM  <= WriteRegE;
                ALUOutM    <= ALUMultOutE;
                WriteDataM <= WriteDataE;
                PCPlus4M   <= PCPlus4E;
            end
        end
    end

    mem_access_fsm #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_mem_access_fsm (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .addrLowM   (ALUOutM[1:0]),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .StallM     (StallM),
        .dropM      (dropM),
        .ErrM       (ErrM)
    );

    assign dmem_we    = MemWriteM & dmem_req;
    assign dmem_addr  = {ALUOutM[31:2], 2'b00};
    assign dmem_wdata = WriteDataM;

    // M/W register: bubble while stalled so the W instruction retires once;
    // misaligned or timed-out ops are also retired as bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW <= 1'b0;
            WriteRegW <= '0;
            jumpW     <= 1'b0;
            MemtoRegW <= MTR_ALU;
            ALUOutW   <= '0;
            ReadDataW <= '0;
            PCPlus4W  <= '0;
        end else if (StallM || dropM) begin
            RegWriteW <= 1'b0;
            WriteRegW <= '0;
            jumpW     <= 1'b0;
            MemtoRegW <= MTR_ALU;
            ALUOutW   <= '0;
            ReadDataW <= '0;
            PCPlus4W  <= '0;
        end else begin
            RegWriteW <= RegWriteM;
            WriteRegW <= WriteRegM;
            jumpW     <= jumpM;
            MemtoRegW <= MemtoRegM;
            ALUOutW   <= ALUOutM;
            ReadDataW <= dmem_rdata;
            PCPlus4W  <= PCPlus4M;
        end
    end

    always_comb begin
        ResultW = ALUOutW;
        if (jumpW) begin
            ResultW = PCPlus4W;
        end else if (MemtoRegW == MTR_MEM) begin
            ResultW = ReadDataW;
        end
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Owns the E/M and M/W pipeline registers and drives the data-memory request/ready handshake through a small access FSM.
- Produces ALUOutM and ResultW as forwarding sources for execute, and StallM for the hazard unit.
- Holds the pipeline while a slow memory access is outstanding.

Parameters:
- TIMEOUT, 64: max cycles in WAIT before the access is aborted and ErrM is raised; must be ≥2.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- RegWriteE  in  1  execute-stage write enable
- MemWriteE  in  1  store
- jumpE  in  1  jump/link
- MemtoRegE  in  2  00 ALU, 01 load, 1x multiplier result (already selected upstream)
- WriteRegE  in  5  destination register
- ALUMultOutE  in  32  address / result
- WriteDataE  in  32  store data
- PCPlus4E  in  32  link value
- FlushM  in  1  hazard unit: squash E/M contents
- dmem_req  out  1  access request
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word address
- dmem_wdata  out  32  store data
- dmem_ready  in  1  access complete
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- ALUOutM  out  32  forwarding source
- WriteRegM  out  5  destination register, for hazard unit
- RegWriteM  out  1  write enable, for hazard unit
- MemtoRegM  out  2  result select, for hazard unit
- StallM  out  1  freeze IF..M
- ErrM  out  1  sticky error (misalign/timeout)
- RegWriteW  out  1  writeback enable
- WriteRegW  out  5  writeback register
- ResultW  out  32  writeback value

Behaviour:
- rst is asynchronous, active-high; clock is clk, posedge. Reset clears every register, the FSM and the counter: all outputs 0, FSM=IDLE.
- E/M register:
  - Captures all E inputs each cycle unless StallM=1 (hold).
  - FlushM=1 with StallM=0 loads a bubble: all control 0, data 0.
  - StallM has priority over FlushM.
- Memory op definitions:
  - MemOpM = MemWriteM | (MemtoRegM==2'b01).
  - Misaligned = MemOpM & (ALUOutM[1:0]!=0).
  - A misaligned op issues no request, sets ErrM, and is retired as a bubble (RegWriteW=0). The write never reaches memory.
- FSM states IDLE, WAIT, both Moore on state plus MemOpM.
  - IDLE, MemOpM aligned: dmem_req=1 combinationally.
    - dmem_ready=1 same cycle: zero-wait, no stall.
    - dmem_ready=0: StallM=1, go to WAIT, cnt=1.
  - WAIT: dmem_req=1, StallM=1, cnt increments.
    - dmem_ready=1: StallM=0 this cycle, data captured into M/W, go to IDLE.
    - cnt==TIMEOUT with no ready: abort, ErrM=1, op retired as bubble, go to IDLE.
  - Request signals:
    - dmem_we = MemWriteM & dmem_req.
    - dmem_addr = {ALUOutM[31:2],2'b00}.
    - dmem_wdata = WriteDataM.
    - All held stable while dmem_req=1.
- ALUOutM = registered ALUMultOutE. RegWriteM, WriteRegM and MemtoRegM are the registered E/M values, exported for forwarding/hazard detection.
- M/W register:
  - Captures when StallM=0.
  - While StallM=1 it loads a bubble (RegWriteW=0), so a W-stage instruction retires exactly once.
- ResultW priority (registered source values):
  1. jumpW: PCPlus4W
  2. MemtoRegW==01: ReadDataW
  3. otherwise: ALUOutW
- ErrM is sticky until rst.
- Reset mid-WAIT: dmem_req drops immediately (asynchronous); the memory side must tolerate an abandoned request.
- FlushM during WAIT is ignored; the access completes first.

Decomposition:
- Shared package (mips_pkg):
  - MemtoReg encodings MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_LO=2'b10, MTR_HI=2'b11
  - FSM state enum
- One sub-module: mem_access_fsm, containing state, counter, req/stall/error generation.
- Pipeline registers and the ResultW mux live in the top module.

Test Plan:
- ALU op: ALUMultOutE=0x1234, RegWriteE=1, WriteRegE=5, MemtoRegE=00 → ALUOutM=0x1234 next cycle; ResultW=0x1234, WriteRegW=5 one cycle later; StallM=0 throughout.
- Zero-wait load: addr 0x40, dmem_ready tied 1, rdata=0xDEADBEEF → dmem_req for one cycle, no stall, ResultW=0xDEADBEEF.
- 3-wait store: MemWriteE=1, addr 0x80, data 0xA5A5A5A5, ready after 3 cycles → StallM high 3 cycles; dmem_we/addr/wdata stable throughout; RegWriteW=0 during stall; E/M holds.
- Misaligned load: addr 0x42 → no dmem_req, ErrM=1 and stays 1, RegWriteW=0 for that op.
- Timeout: TIMEOUT=4, ready never asserted → StallM high exactly 4 cycles, ErrM=1, FSM back to IDLE, following ALU op retires normally.
- Async rst asserted mid-WAIT → dmem_req, StallM, RegWriteW drop to 0 without a clock edge; flush bubble (FlushM=1) → RegWriteW=0 two cycles later.
